// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE -> FETCH -> DECODE -> EXECUTE
// -> (MEM) -> WB, with a bus-wait timeout that parks the sequencer in HALT.
// Control outputs are decoded from the registered state so that an
// asynchronous reset drops every request in the same cycle.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             imem_ready_i,
    input  logic             mem_ready_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             is_branch_i,
    input  logic             is_jump_i,
    input  logic             reg_write_i,
    input  logic             illegal_i,
    input  logic             branch_taken_i,
    output logic             imem_req_o,
    output logic             ir_load_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             rf_wen_o,
    output logic [1:0]       wb_sel_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_sel_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             bus_error_o,
    output logic [CNT_W-1:0] retired_o
);

    // The wait counter only has to reach TIMEOUT-1 before the timeout fires.
    localparam int unsigned      WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_e;

    state_e             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   retired_q;
    logic               bus_error_q;
    logic               ld_q, st_q, br_q, jmp_q, rw_q;
    logic               retire_d;

    // Control decode from the current state and the latched instruction class.
    always_comb begin
        imem_req_o = 1'b0;
        ir_load_o  = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        rf_wen_o   = 1'b0;
        wb_sel_o   = 2'b00;
        pc_write_o = 1'b0;
        pc_sel_o   = 2'b00;
        retire_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_load_o  = imem_ready_i;
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = st_q;
                // A store retires as soon as the data memory accepts it.
                if (st_q && mem_ready_i) begin
                    pc_write_o = 1'b1;
                    retire_d   = 1'b1;
                end
            end
            S_WB: begin
                // A jump that is also flagged as a branch behaves as a jump,
                // so its link write is not suppressed by the branch flag.
                rf_wen_o   = rw_q && !st_q && (!br_q || jmp_q);
                wb_sel_o   = ld_q ? 2'b01 : (jmp_q ? 2'b10 : 2'b00);
                pc_write_o = 1'b1;
                pc_sel_o   = jmp_q ? 2'b10 : ((br_q && branch_taken_i) ? 2'b01 : 2'b00);
                retire_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, wait counter, latched instruction class and retire count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            br_q        <= 1'b0;
            jmp_q       <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            if (retire_d) begin
                retired_q <= retired_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready_i) begin
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q     <= S_HALT;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    ld_q  <= is_load_i;
                    st_q  <= is_store_i;
                    br_q  <= is_branch_i;
                    jmp_q <= is_jump_i;
                    rw_q  <= reg_write_i;
                    if (illegal_i || (is_load_i && is_store_i)) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (ld_q || st_q) begin
                        state_q <= S_MEM;
                        wait_q  <= '0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        if (st_q) begin
                            state_q <= run_i ? S_FETCH : S_IDLE;
                            wait_q  <= '0;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_q     <= S_HALT;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= run_i ? S_FETCH : S_IDLE;
                    wait_q  <= '0;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o     = state_q;
    assign halted_o    = (state_q == S_HALT);
    assign bus_error_o = bus_error_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: expected retire records are queued
// when an instruction is launched and compared when the DUT retires it.
module tb_cpu_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       run_i = 1'b0;
    logic       imem_ready_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       is_load_i = 1'b0;
    logic       is_store_i = 1'b0;
    logic       is_branch_i = 1'b0;
    logic       is_jump_i = 1'b0;
    logic       reg_write_i = 1'b0;
    logic       illegal_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       imem_req_o, ir_load_o, mem_req_o, mem_we_o, rf_wen_o;
    logic [1:0] wb_sel_o, pc_sel_o;
    logic       pc_write_o;
    logic [2:0] state_o;
    logic       halted_o, bus_error_o;
    logic [3:0] retired_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ret   = 0;
    logic mon_en  = 1'b0;
    logic [3:0] ret_model = 4'd0;

    typedef struct packed {
        logic       rf;
        logic [1:0] wb;
        logic [1:0] pc;
        logic       we;
        logic [3:0] ret;
    } exp_t;
    exp_t sb[$];

    cpu_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i),
        .imem_ready_i(imem_ready_i), .mem_ready_i(mem_ready_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i),
        .reg_write_i(reg_write_i), .illegal_i(illegal_i),
        .branch_taken_i(branch_taken_i),
        .imem_req_o(imem_req_o), .ir_load_o(ir_load_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .rf_wen_o(rf_wen_o),
        .wb_sel_o(wb_sel_o), .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o),
        .state_o(state_o), .halted_o(halted_o), .bus_error_o(bus_error_o),
        .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        run_i = 0; imem_ready_i = 0; mem_ready_i = 0; branch_taken_i = 0;
        is_load_i = 0; is_store_i = 0; is_branch_i = 0; is_jump_i = 0;
        reg_write_i = 0; illegal_i = 0;
    endtask

    // Assert reset now, check outputs respond immediately, release later.
    task automatic reset_now();
        rst_ni = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_reqs", 32'({imem_req_o, ir_load_o, mem_req_o, mem_we_o, rf_wen_o, pc_write_o}), 32'd0);
        chk("rst_sels", 32'({wb_sel_o, pc_sel_o}), 32'd0);
        chk("rst_halt_err", 32'({halted_o, bus_error_o}), 32'd0);
        chk("rst_retired", 32'(retired_o), 32'd0);
        clear_inputs();
        ret_model = 4'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
    endtask

    // Launch one instruction from IDLE with run pulsed for a single cycle.
    task automatic do_instr(input logic ld, input logic st, input logic br, input logic jmp,
                            input logic rw, input logic tk, input int wait_n,
                            input logic e_rf, input logic [1:0] e_wb, input logic [1:0] e_pc);
        exp_t e;
        e.rf = e_rf; e.wb = e_wb; e.pc = e_pc; e.we = st; e.ret = ret_model;
        sb.push_back(e);
        ret_model = ret_model + 4'd1;
        cyc();
        mem_ready_i = 0; branch_taken_i = 0; run_i = 1; imem_ready_i = 1;
        is_load_i = ld; is_store_i = st; is_branch_i = br; is_jump_i = jmp; reg_write_i = rw;
        @(negedge clk_i);
        chk("idle_state", 32'(state_o), 32'd0);
        cyc();
        run_i = 0;
        @(negedge clk_i);
        chk("fetch_state", 32'(state_o), 32'd1);
        chk("fetch_imem_req", 32'(imem_req_o), 32'd1);
        chk("fetch_ir_load", 32'(ir_load_o), 32'd1);
        cyc();
        imem_ready_i = 0;
        @(negedge clk_i);
        chk("decode_state", 32'(state_o), 32'd2);
        chk("decode_ir_load", 32'(ir_load_o), 32'd0);
        cyc();
        is_load_i = 0; is_store_i = 0; is_branch_i = 0; is_jump_i = 0; reg_write_i = 0;
        @(negedge clk_i);
        chk("exec_state", 32'(state_o), 32'd3);
        if (ld || st) begin
            for (int k = 0; k <= wait_n; k++) begin
                cyc();
                mem_ready_i = (k == wait_n);
                @(negedge clk_i);
                chk("mem_state", 32'(state_o), 32'd4);
                chk("mem_req", 32'(mem_req_o), 32'd1);
                chk("mem_we", 32'(mem_we_o), 32'(st));
            end
        end
        if (!st) begin
            cyc();
            mem_ready_i = 0;
            branch_taken_i = tk;
            @(negedge clk_i);
            chk("wb_state", 32'(state_o), 32'd5);
        end
    endtask

    // Drive an instruction that must halt in DECODE, then confirm HALT sticks.
    task automatic do_bad(input logic ld, input logic st, input logic ill);
        cyc();
        mem_ready_i = 0; run_i = 1; imem_ready_i = 1;
        is_load_i = ld; is_store_i = st; illegal_i = ill;
        cyc();
        run_i = 0;
        cyc();
        imem_ready_i = 0;
        @(negedge clk_i);
        chk("bad_decode_state", 32'(state_o), 32'd2);
        cyc();
        clear_inputs();
        @(negedge clk_i);
        chk("bad_halt_state", 32'(state_o), 32'd6);
        chk("bad_halted", 32'(halted_o), 32'd1);
        chk("bad_bus_error", 32'(bus_error_o), 32'd0);
        run_i = 1; imem_ready_i = 1; mem_ready_i = 1;
        repeat (3) begin
            @(negedge clk_i);
            chk("bad_halt_stays", 32'({state_o, halted_o, bus_error_o}), 32'({3'd6, 1'b1, 1'b0}));
            chk("bad_halt_quiet", 32'({imem_req_o, mem_req_o, pc_write_o, rf_wen_o}), 32'd0);
        end
    endtask

    // Retire monitor: pops the expected record on every retire cycle.
    always @(negedge clk_i) begin
        if (mon_en && rst_ni) begin
            chk("req_exclusive", 32'(imem_req_o & mem_req_o), 32'd0);
            chk("rf_wen_stray", 32'(rf_wen_o & ~pc_write_o), 32'd0);
            if (pc_write_o) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_retire", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_ret++;
                    $display("[TB] retire %0d: rf_wen=%0b wb_sel=%0d pc_sel=%0d mem_we=%0b retired=%0d",
                             n_ret, rf_wen_o, wb_sel_o, pc_sel_o, mem_we_o, retired_o);
                    chk("ret_rf_wen", 32'(rf_wen_o), 32'(e.rf));
                    chk("ret_wb_sel", 32'(wb_sel_o), 32'(e.wb));
                    chk("ret_pc_sel", 32'(pc_sel_o), 32'(e.pc));
                    chk("ret_mem_we", 32'(mem_we_o), 32'(e.we));
                    chk("ret_count", 32'(retired_o), 32'(e.ret));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk_i);
        #2;
        reset_now();

        //        ld st br jp rw tk wait  rf  wb     pc
        do_instr(0, 0, 0, 0, 1, 0, 0,    1, 2'b00, 2'b00); // ALU op
        do_instr(1, 0, 0, 0, 1, 0, 2,    1, 2'b01, 2'b00); // load, 3 MEM cycles
        do_instr(0, 1, 0, 0, 0, 0, 0,    0, 2'b00, 2'b00); // store
        do_instr(0, 0, 1, 0, 0, 1, 0,    0, 2'b00, 2'b01); // branch taken
        do_instr(0, 0, 1, 0, 1, 0, 0,    0, 2'b00, 2'b00); // branch not taken
        do_instr(0, 0, 1, 1, 1, 1, 0,    1, 2'b10, 2'b10); // jump + branch + link
        do_instr(0, 0, 0, 1, 0, 0, 0,    0, 2'b10, 2'b10); // plain jump
        do_instr(0, 1, 0, 0, 1, 0, 1,    0, 2'b00, 2'b00); // store with reg_write
        do_instr(1, 0, 0, 0, 1, 0, 0,    1, 2'b01, 2'b00); // load, no wait
        cyc();
        @(negedge clk_i);
        chk("retired_after_9", 32'(retired_o), 32'(ret_model));
        chk("idle_after_run_drop", 32'(state_o), 32'd0);

        // Reset while a load waits in MEM: requests drop at once, nothing retires.
        cyc();
        run_i = 1; imem_ready_i = 1; is_load_i = 1; reg_write_i = 1;
        cyc();
        run_i = 0;
        cyc();
        imem_ready_i = 0;
        cyc();
        clear_inputs();
        cyc();
        @(negedge clk_i);
        chk("pre_rst_mem_req", 32'(mem_req_o), 32'd1);
        #2;
        reset_now();

        // Sixteen retires on a 4-bit counter wrap back to zero.
        for (int i = 0; i < 16; i++) begin
            do_instr(0, 0, 0, 0, i[0], 0, 0, i[0], 2'b00, 2'b00);
        end
        cyc();
        @(negedge clk_i);
        chk("retired_wrap", 32'(retired_o), 32'd0);

        do_bad(0, 0, 1);
        @(posedge clk_i); #2; reset_now();
        do_bad(1, 1, 0);
        @(posedge clk_i); #2; reset_now();

        // Data memory never answers: HALT with bus_error after 4 wait cycles.
        cyc();
        run_i = 1; imem_ready_i = 1; is_load_i = 1;
        cyc();
        run_i = 0;
        cyc();
        imem_ready_i = 0;
        cyc();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk_i);
            chk("to_mem_state", 32'(state_o), 32'd4);
            chk("to_mem_req", 32'(mem_req_o), 32'd1);
            chk("to_no_err_yet", 32'(bus_error_o), 32'd0);
        end
        cyc();
        @(negedge clk_i);
        chk("to_halt_state", 32'(state_o), 32'd6);
        chk("to_halted", 32'(halted_o), 32'd1);
        chk("to_bus_error", 32'(bus_error_o), 32'd1);
        chk("to_mem_req_off", 32'(mem_req_o), 32'd0);
        run_i = 1; mem_ready_i = 1; imem_ready_i = 1;
        repeat (3) begin
            @(negedge clk_i);
            chk("to_halt_stays", 32'({state_o, halted_o, bus_error_o}), 32'({3'd6, 1'b1, 1'b1}));
        end
        @(posedge clk_i); #2; reset_now();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles to wait for imem_ready/mem_ready before bus error.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  enable instruction sequencing.
REQ-006 imem_ready  input  1  instruction memory has valid instruction.
REQ-007 mem_ready  input  1  data memory has completed the access.
REQ-008 is_load, is_store, is_branch, is_jump, reg_write, illegal  input  1 each  decoded instruction class from control unit, valid in DECODE.
REQ-009 branch_taken  input  1  branch comparison result, valid in WB.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_load  output  1  latch instruction register.
REQ-012 mem_req  output  1  data memory request.
REQ-013 mem_we  output  1  data memory write (store).
REQ-014 rf_wen  output  1  register file write enable.
REQ-015 wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-016 pc_write  output  1  update PC.
REQ-017 pc_sel  output  2  next PC: 00 PC+4, 01 branch target, 10 jump target.
REQ-018 state  output  3  current FSM state encoding.
REQ-019 halted, bus_error  output  1 each  sequencer stopped; stop caused by timeout.
REQ-020 retired  output  CNT_W  count of retired instructions.

Function
REQ-021 FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6; 7 unused, recovers to IDLE next cycle.
REQ-022 IDLE: run=1 -> FETCH; otherwise remain.
REQ-023 FETCH: imem_req=1 every cycle; on imem_ready=1 ir_load=1 in that same cycle (combinational), -> DECODE.
REQ-024 DECODE: register is_load, is_store, is_branch, is_jump, reg_write; illegal=1 or (is_load and is_store) -> HALT; else -> EXECUTE.
REQ-025 EXECUTE: one cycle; latched load or store -> MEM; else -> WB.
REQ-026 MEM: mem_req=1 and mem_we=latched store held until mem_ready=1; load then -> WB; store retires in that cycle (pc_write=1, pc_sel=00) -> FETCH if run=1 else IDLE.
REQ-027 WB: one cycle; rf_wen=latched reg_write and not store/branch; wb_sel=01 for load, 10 for jump, else 00; pc_write=1.
REQ-028 pc_sel in WB: jump -> 10; branch with branch_taken=1 -> 01; else 00; jump has priority over branch if both latched.
REQ-029 WB next state: FETCH if run=1, else IDLE.
REQ-030 retired SHALL increment by 1 on each retire cycle (WB, or MEM store completion); wraps to 0 after all-ones.
REQ-031 Wait counter SHALL reset to 0 on entry to FETCH or MEM and count each waiting cycle; reaching TIMEOUT without ready -> HALT with bus_error=1.
REQ-032 run deasserted mid-instruction SHALL NOT abort it; instruction completes, then IDLE.
REQ-033 HALT: halted=1, all request/enable outputs 0; exit only by reset.
REQ-034 Outputs not listed active for a state SHALL be 0 in that state; mem_req and imem_req never both 1.

Reset
REQ-035 rst=0 SHALL asynchronously force state=IDLE, all outputs 0, retired=0, wait counter 0, latched flags 0, halted=0, bus_error=0.
REQ-036 rst assertion mid-MEM or mid-FETCH SHALL drop mem_req/imem_req within the same cycle, no retire counted.
REQ-037 After rst returns high, first FETCH SHALL occur in the cycle after run=1 is sampled in IDLE.

Verification
REQ-038 ALU op: run=1, imem_ready=1 immediately, reg_write=1 -> states 1,2,3,5; rf_wen=1, wb_sel=00, pc_sel=00 in WB; retired=1.
REQ-039 Load with 3-cycle memory wait: is_load=1, mem_ready high on 3rd MEM cycle -> mem_req high 3 cycles, then WB with rf_wen=1, wb_sel=01.
REQ-040 Store: is_store=1, mem_ready=1 -> mem_we=1, pc_write=1 in MEM, no WB, rf_wen never 1, retired +1.
REQ-041 Branch taken and jump: is_branch=1, branch_taken=1 -> pc_sel=01, rf_wen=0; is_jump=1, is_branch=1, reg_write=1 -> pc_sel=10, wb_sel=10, rf_wen=1.
REQ-042 Timeout and illegal: mem_ready held 0 with TIMEOUT=4 -> HALT, bus_error=1 after 4 wait cycles; illegal=1 -> HALT, bus_error=0; both stay until rst=0.
REQ-043 Reset mid-MEM and retired wrap: rst=0 while mem_req=1 -> all outputs 0 immediately; CNT_W=4, 16 retires -> retired=0.
